// File: rtl/axi_wr_master_ot.sv
// AXI4 write master with up to MAX_OUTSTANDING bursts in flight; W beats are gated by per-burst credits.
// Build macro WR_BRESP_ERR_EN adds a sticky BRESP error flag (wr_err) and first-error id (wr_err_id).
module axi_wr_master_ot #(
  parameter int         AXI_ADDR_WIDTH  = 32,
  parameter int         AXI_DATA_WIDTH  = 128,
  parameter logic [3:0] AXI_ID          = 4'd0,
  parameter int         MAX_OUTSTANDING = 4
) (
  input  logic                        axi_clk,
  input  logic                        a_rst_sync,
  input  logic                        axi_aw_req_en,
  output logic                        axi_aw_ready,
  input  logic [7:0]                  axi_aw_burst_len,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
  input  logic                        axi_w_valid,
  output logic                        axi_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
  input  logic                        axi_w_last,
  output logic                        wr_done,
  output logic                        wr_busy,
  output logic                        m_axi_awvalid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [3:0]                  m_axi_awid,
  output logic [7:0]                  m_axi_awlen,
  output logic [1:0]                  m_axi_awburst,
  output logic [2:0]                  m_axi_awsize,
  output logic [2:0]                  m_axi_awprot,
  output logic [3:0]                  m_axi_awqos,
  output logic                        m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  input  logic                        m_axi_awready,
  output logic                        m_axi_wvalid,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  input  logic                        m_axi_wready,
  input  logic [3:0]                  m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
`ifdef WR_BRESP_ERR_EN
  output logic                        wr_err,
  output logic [3:0]                  wr_err_id,
`endif
  output logic                        m_axi_bready
);

  localparam int         STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [2:0] AWSIZE = 3'($clog2(STRB_W));
  localparam logic [3:0] MAX_OT = 4'(MAX_OUTSTANDING);

  logic [3:0]                ost_cnt_q, ost_cnt_d;
  logic [3:0]                wcred_q, wcred_d;
  logic                      awvalid_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]                awlen_q;
  logic                      wvalid_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]         wstrb_q;
  logic                      wlast_q;
  logic                      wr_done_q;
  logic                      aw_acc, w_acc, w_last_acc, b_take;

  // Output stages may reload in the same cycle they hand off, so no bubbles.
  assign axi_aw_ready = (ost_cnt_q < MAX_OT) && (!awvalid_q || m_axi_awready);
  assign axi_w_ready  = (wcred_q != 4'd0) && (!wvalid_q || m_axi_wready);
  assign aw_acc       = axi_aw_req_en && axi_aw_ready;
  assign w_acc        = axi_w_valid && axi_w_ready;
  assign w_last_acc   = w_acc && axi_w_last;
  // A stray B with nothing outstanding is dropped entirely.
  assign b_take       = m_axi_bvalid && m_axi_bready && (ost_cnt_q != 4'd0);

  always_comb begin
    ost_cnt_d = ost_cnt_q;
    wcred_d   = wcred_q;
    case ({aw_acc, b_take})
      2'b10:   ost_cnt_d = ost_cnt_q + 4'd1;
      2'b01:   ost_cnt_d = ost_cnt_q - 4'd1;
      default: ost_cnt_d = ost_cnt_q;
    endcase
    case ({aw_acc, w_last_acc})
      2'b10:   wcred_d = wcred_q + 4'd1;
      2'b01:   wcred_d = wcred_q - 4'd1;
      default: wcred_d = wcred_q;
    endcase
  end

  always_ff @(posedge axi_clk or negedge a_rst_sync) begin
    if (!a_rst_sync) begin
      ost_cnt_q <= 4'd0;
      wcred_q   <= 4'd0;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= 8'd0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wlast_q   <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      ost_cnt_q <= ost_cnt_d;
      wcred_q   <= wcred_d;
      wr_done_q <= b_take;
      if (aw_acc) begin
        awvalid_q <= 1'b1;
        awaddr_q  <= axi_aw_addr;
        awlen_q   <= axi_aw_burst_len;
      end else if (m_axi_awready) begin
        awvalid_q <= 1'b0;
      end
      if (w_acc) begin
        wvalid_q <= 1'b1;
        wdata_q  <= axi_w_data;
        wstrb_q  <= axi_w_strb;
        wlast_q  <= axi_w_last;
      end else if (m_axi_wready) begin
        wvalid_q <= 1'b0;
      end
    end
  end

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awid    = AXI_ID;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awsize  = AWSIZE;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_bready  = 1'b1;
  assign wr_done       = wr_done_q;
  assign wr_busy       = (ost_cnt_q != 4'd0) || awvalid_q || wvalid_q;

`ifdef WR_BRESP_ERR_EN
  logic       wr_err_q;
  logic [3:0] wr_err_id_q;

  // Sticky until reset; the id is frozen at the first SLVERR/DECERR.
  always_ff @(posedge axi_clk or negedge a_rst_sync) begin
    if (!a_rst_sync) begin
      wr_err_q    <= 1'b0;
      wr_err_id_q <= 4'd0;
    end else if (b_take && m_axi_bresp[1] && !wr_err_q) begin
      wr_err_q    <= 1'b1;
      wr_err_id_q <= m_axi_bid;
    end
  end

  assign wr_err    = wr_err_q;
  assign wr_err_id = wr_err_id_q;
`else
  logic unused_b;
  assign unused_b = ^{m_axi_bid, m_axi_bresp};
`endif

endmodule
